sipo_frame_ctrl: RTL

//  Sequencer for the 8-bit serial-in/parallel-out shift register: detects a start bit on
//  ser_in, drives the register's shift-enable/clear at mid-bit sample points, checks the

---
 rtl/sipo_frame_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/sipo_frame_ctrl.sv
// sipo_frame_ctrl: start/stop framing sequencer for an external 8-bit SIPO
// shift register. It detects the start bit, strobes shift/clear at mid-bit,
// checks the stop bit and offers the captured word on a valid/ready port.
// Optional feature: define PARITY_CHECK_EN to add an even-parity bit between
// the data bits and the stop bit, together with the par_err output.
module sipo_frame_ctrl #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              R_n,
  input  logic              ser_in,
  input  logic [DATA_W-1:0] par_in,
  output logic              shift_en,
  output logic              shift_clr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              frame_err,
`ifdef PARITY_CHECK_EN
  output logic              par_err,
`endif
  output logic              overrun
);

  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef PARITY_CHECK_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t            state_q;
  logic [BAUD_W-1:0] baud_cnt_q;
  logic [BIT_W-1:0]  bit_cnt_q;
  logic [1:0]        sync_q;
  logic [1:0]        sync_d;
  logic              rx;
  logic              baud_tick;
`ifdef PARITY_CHECK_EN
  logic              par_flag_q;
`endif

  // Next value of the two-stage synchroniser; rx is the settled line.
  always_comb begin
    sync_d    = {sync_q[0], ser_in};
    rx        = sync_q[1];
    baud_tick = (baud_cnt_q == BAUD_LAST);
  end

  // Synchroniser flops reset to the idle-high line level.
  always_ff @(posedge clk or negedge R_n) begin
    if (!R_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  // Frame sequencer with registered strobes, handshake and status outputs.
  always_ff @(posedge clk or negedge R_n) begin
    if (!R_n) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_en   <= 1'b0;
      shift_clr  <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_err    <= 1'b0;
      par_flag_q <= 1'b0;
`endif
    end else begin
      shift_en  <= 1'b0;
      shift_clr <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_err   <= 1'b0;
`endif
      // A load later in this block overrides the consume, keeping valid high.
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
`ifdef PARITY_CHECK_EN
          par_flag_q <= 1'b0;
`endif
          if (!rx) begin
            state_q    <= ST_START;
            baud_cnt_q <= '0;
            shift_clr  <= 1'b1;
            busy       <= 1'b1;
          end
        end

        ST_START: begin
          if (baud_cnt_q == BAUD_HALF) begin
            if (rx) begin
              state_q <= ST_IDLE;
              busy    <= 1'b0;
            end else begin
              state_q    <= ST_DATA;
              baud_cnt_q <= '0;
              bit_cnt_q  <= '0;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end

        ST_DATA: begin
          if (baud_tick) begin
            baud_cnt_q <= '0;
            shift_en   <= 1'b1;
            bit_cnt_q  <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == BIT_LAST) begin
`ifdef PARITY_CHECK_EN
              state_q <= ST_PARITY;
`else
              state_q <= ST_STOP;
`endif
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end

`ifdef PARITY_CHECK_EN
        ST_PARITY: begin
          if (baud_tick) begin
            baud_cnt_q <= '0;
            state_q    <= ST_STOP;
            if ((^par_in) ^ rx) begin
              par_flag_q <= 1'b1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
`endif

        ST_STOP: begin
          if (baud_tick) begin
            baud_cnt_q <= '0;
            if (rx) begin
              state_q <= ST_IDLE;
              busy    <= 1'b0;
`ifdef PARITY_CHECK_EN
              if (par_flag_q) begin
                par_err <= 1'b1;
              end else
`endif
              if (out_valid && !out_ready) begin
                overrun <= 1'b1;
              end else begin
                out_data  <= par_in;
                out_valid <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state_q   <= ST_BREAK;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end

        ST_BREAK: begin
          if (rx) begin
            state_q <= ST_IDLE;
            busy    <= 1'b0;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
